// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch constants plus the IF/ID load-source selection used by the fetch unit.
// Memory and decode import the same widths and encodings from here.
package instruction_fetch_unit_pkg;

    localparam int          IFU_ADDR_W    = 16;
    localparam int          IFU_INSTR_W   = 16;
    localparam logic [15:0] IFU_RESET_PC  = 16'h0000;
    localparam logic [15:0] IFU_NOP_INSTR = 16'hF000;

    typedef enum logic [2:0] {
        LOAD_HOLD     = 3'd0,
        LOAD_FLUSH    = 3'd1,
        LOAD_SKID     = 3'd2,
        LOAD_INFLIGHT = 3'd3,
        LOAD_BUBBLE   = 3'd4
    } load_sel_e;

    // Redirect beats stall; a parked skid word is older than the in-flight read.
    function automatic load_sel_e ifu_load_sel(
        input logic redirect,
        input logic stall,
        input logic skid_v,
        input logic inflight_v
    );
        load_sel_e sel;
        if (redirect) begin
            sel = LOAD_FLUSH;
        end else if (stall) begin
            sel = LOAD_HOLD;
        end else if (skid_v) begin
            sel = LOAD_SKID;
        end else if (inflight_v) begin
            sel = LOAD_INFLIGHT;
        end else begin
            sel = LOAD_BUBBLE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry holding register for an instruction returned while ID is stalled.
// Clear wins over capture, and capture wins over drain.
module instruction_fetch_unit_skid
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W    = IFU_ADDR_W,
    parameter int                 INSTR_W   = IFU_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture_i,
    input  logic               drain_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads to synchronous imem, absorbs the
// one-cycle read latency across ID stalls and redirects, and drives the IF/ID register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W    = IFU_ADDR_W,
    parameter int                 INSTR_W   = IFU_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = IFU_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_target_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic               if_id_valid_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic [ADDR_W-1:0]  if_id_pc_plus1_o
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [ADDR_W-1:0]  ifid_pc1_q, ifid_pc1_d;

    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               skid_capture;
    logic               skid_drain;
    load_sel_e          load_sel;

    assign load_sel     = ifu_load_sel(redirect_i, stall_i, skid_valid, inflight_v_q);
    assign skid_capture = stall_i && !redirect_i && inflight_v_q;
    assign skid_drain   = (load_sel == LOAD_SKID);

    instruction_fetch_unit_skid #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .capture_i (skid_capture),
        .drain_i   (skid_drain),
        .clear_i   (redirect_i),
        .instr_i   (imem_instr_i),
        .pc_i      (inflight_pc_q),
        .valid_o   (skid_valid),
        .instr_o   (skid_instr),
        .pc_o      (skid_pc)
    );

    // A stalled cycle issues nothing: memory re-reads pc_q and that data is ignored.
    always_comb begin
        pc_d          = pc_q;
        inflight_v_d  = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            pc_d = redirect_target_i;
        end else if (!stall_i) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_v_d  = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc1_d   = ifid_pc1_q;
        case (load_sel)
            LOAD_FLUSH, LOAD_BUBBLE: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
            LOAD_SKID: begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr;
                ifid_pc_d    = skid_pc;
                ifid_pc1_d   = skid_pc + ADDR_W'(1);
            end
            LOAD_INFLIGHT: begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_instr_i;
                ifid_pc_d    = inflight_pc_q;
                ifid_pc1_d   = inflight_pc_q + ADDR_W'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= '0;
            ifid_pc1_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc1_q    <= ifid_pc1_d;
        end
    end

    assign imem_addr_o      = pc_q;
    assign if_id_valid_o    = ifid_valid_q;
    assign if_id_instr_o    = ifid_instr_q;
    assign if_id_pc_o       = ifid_pc_q;
    assign if_id_pc_plus1_o = ifid_pc1_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a small synchronous imem image.
// Each vector drives inputs for one clock edge and gives the IF/ID contents expected after it.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [15:0] tgt;
        logic [48:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_target_i;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_instr_i;
    logic        if_id_valid_o;
    logic [15:0] if_id_instr_o;
    logic [15:0] if_id_pc_o;
    logic [15:0] if_id_pc_plus1_o;
    logic [48:0] obs;

    int passed = 0;
    int total  = 0;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_addr_o       (imem_addr_o),
        .imem_instr_i      (imem_instr_i),
        .if_id_valid_o     (if_id_valid_o),
        .if_id_instr_o     (if_id_instr_o),
        .if_id_pc_o        (if_id_pc_o),
        .if_id_pc_plus1_o  (if_id_pc_plus1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h0764;
            16'd1:   return 16'h1031;
            16'd2:   return 16'h3241;
            16'd3:   return 16'h1002;
            16'd4:   return 16'h0164;
            16'd5:   return 16'h10A0;
            16'd6:   return 16'h4F84;
            16'd7:   return 16'h0A57;
            default: return 16'hF000;
        endcase
    endfunction

    initial imem_instr_i = 16'hF000;
    always @(posedge clk) imem_instr_i <= mem_word(imem_addr_o);

    assign obs = {if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o};

    function automatic logic [48:0] pk(input logic v, input logic [15:0] ins,
                                       input logic [15:0] pc, input logic [15:0] pc1);
        return {v, ins, pc, pc1};
    endfunction

    function automatic vec_t mk(input logic rst, input logic stl, input logic rdr,
                                input logic [15:0] tgt, input logic [48:0] exp);
        vec_t r;
        r.rst = rst;
        r.stl = stl;
        r.rdr = rdr;
        r.tgt = tgt;
        r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        reset             = v.rst;
        stall_i           = v.stl;
        redirect_i        = v.rdr;
        redirect_target_i = v.tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v [2];
        v[0] = mk(1, 0, 0, 16'h0, pk(0, 16'hF000, 16'h0, 16'h0));
        v[1] = mk(1, 0, 0, 16'h0, pk(0, 16'hF000, 16'h0, 16'h0));
        for (int i = 0; i < 2; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL reset[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
        total++;
        if (imem_addr_o !== 16'h0000)
            $display("FAIL reset_addr: got %h, want 0000", imem_addr_o);
        else passed++;
    endtask

    task automatic test_sequential();
        vec_t v [4];
        v[0] = mk(0, 0, 0, 16'h0, pk(0, 16'hF000, 16'h0, 16'h0));
        v[1] = mk(0, 0, 0, 16'h0, pk(1, 16'h0764, 16'h0, 16'h1));
        v[2] = mk(0, 0, 0, 16'h0, pk(1, 16'h1031, 16'h1, 16'h2));
        v[3] = mk(0, 0, 0, 16'h0, pk(1, 16'h3241, 16'h2, 16'h3));
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL sequential[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
        total++;
        if (imem_addr_o !== 16'h0004)
            $display("FAIL sequential_addr: got %h, want 0004", imem_addr_o);
        else passed++;
    endtask

    task automatic test_stall();
        vec_t v [5];
        v[0] = mk(0, 1, 0, 16'h0, pk(1, 16'h3241, 16'h2, 16'h3));
        v[1] = mk(0, 1, 0, 16'h0, pk(1, 16'h3241, 16'h2, 16'h3));
        v[2] = mk(0, 1, 0, 16'h0, pk(1, 16'h3241, 16'h2, 16'h3));
        v[3] = mk(0, 0, 0, 16'h0, pk(1, 16'h1002, 16'h3, 16'h4));
        v[4] = mk(0, 0, 0, 16'h0, pk(1, 16'h0164, 16'h4, 16'h5));
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL stall[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
        total++;
        if (imem_addr_o !== 16'h0006)
            $display("FAIL stall_addr: got %h, want 0006", imem_addr_o);
        else passed++;
    endtask

    task automatic test_redirect();
        vec_t v [8];
        v[0] = mk(0, 0, 1, 16'h0000, pk(0, 16'hF000, 16'h4, 16'h5));
        v[1] = mk(0, 0, 0, 16'h0000, pk(0, 16'hF000, 16'h4, 16'h5));
        v[2] = mk(0, 0, 0, 16'h0000, pk(1, 16'h0764, 16'h0, 16'h1));
        v[3] = mk(0, 0, 0, 16'h0000, pk(1, 16'h1031, 16'h1, 16'h2));
        v[4] = mk(0, 0, 1, 16'h0003, pk(0, 16'hF000, 16'h1, 16'h2));
        v[5] = mk(0, 0, 0, 16'h0000, pk(0, 16'hF000, 16'h1, 16'h2));
        v[6] = mk(0, 0, 0, 16'h0000, pk(1, 16'h1002, 16'h3, 16'h4));
        v[7] = mk(0, 0, 0, 16'h0000, pk(1, 16'h0164, 16'h4, 16'h5));
        for (int i = 0; i < 8; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL redirect[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
    endtask

    task automatic test_redirect_stall();
        vec_t v [5];
        v[0] = mk(0, 1, 0, 16'h0000, pk(1, 16'h0164, 16'h4, 16'h5));
        v[1] = mk(0, 1, 1, 16'h0006, pk(0, 16'hF000, 16'h4, 16'h5));
        v[2] = mk(0, 0, 0, 16'h0000, pk(0, 16'hF000, 16'h4, 16'h5));
        v[3] = mk(0, 0, 0, 16'h0000, pk(1, 16'h4F84, 16'h6, 16'h7));
        v[4] = mk(0, 0, 0, 16'h0000, pk(1, 16'h0A57, 16'h7, 16'h8));
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL redirect_stall[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        vec_t v [5];
        v[0] = mk(0, 0, 1, 16'hFFFF, pk(0, 16'hF000, 16'h7,    16'h8));
        v[1] = mk(0, 0, 0, 16'h0000, pk(0, 16'hF000, 16'h7,    16'h8));
        v[2] = mk(0, 0, 0, 16'h0000, pk(1, 16'hF000, 16'hFFFF, 16'h0000));
        v[3] = mk(0, 0, 0, 16'h0000, pk(1, 16'h0764, 16'h0,    16'h1));
        v[4] = mk(0, 0, 0, 16'h0000, pk(1, 16'h1031, 16'h1,    16'h2));
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL wrap[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        vec_t v [5];
        v[0] = mk(0, 1, 0, 16'h0, pk(1, 16'h1031, 16'h1, 16'h2));
        v[1] = mk(1, 0, 0, 16'h0, pk(0, 16'hF000, 16'h0, 16'h0));
        v[2] = mk(0, 0, 0, 16'h0, pk(0, 16'hF000, 16'h0, 16'h0));
        v[3] = mk(0, 0, 0, 16'h0, pk(1, 16'h0764, 16'h0, 16'h1));
        v[4] = mk(0, 0, 0, 16'h0, pk(1, 16'h1031, 16'h1, 16'h2));
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            step();
            total++;
            if (obs !== v[i].exp)
                $display("FAIL reset_midstream[%0d]: got v=%0b ins=%h pc=%h pc1=%h, want v=%0b ins=%h pc=%h pc1=%h",
                         i, obs[48], obs[47:32], obs[31:16], obs[15:0],
                         v[i].exp[48], v[i].exp[47:32], v[i].exp[31:16], v[i].exp[15:0]);
            else passed++;
            if (i == 1) begin
                total++;
                if (imem_addr_o !== 16'h0000)
                    $display("FAIL reset_midstream_addr: got %h, want 0000", imem_addr_o);
                else passed++;
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = 16'h0000;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
